// File: rtl/contrast_bright_px.sv
`default_nettype none
// ============================================================================
//  Module      : contrast_bright_px
//  Description : Contrast / brightness stage for a CH x DW-bit pixel stream.
//                Three-stage pipeline (centre, multiply, round+offset+clamp).
//                The control set is shadowed into active registers on the
//                Vsync leading edge or on every cycle. Upd_o pulses for one
//                cycle after each frame-synchronous load.
//  Revision    : 1.0  initial release
// ============================================================================
module contrast_bright_px #(
    parameter int DW       = 8,
    parameter int CH       = 3,
    parameter int VS_POL   = 1,
    parameter int UPD_MODE = 0
) (
    input  logic               Pclk,
    input  logic               Rst,
    input  logic               Vsync,
    input  logic               Hsync,
    input  logic               De,
    input  logic [CH*DW-1:0]   Data,
    input  logic               CONTRAST_SIG,
    input  logic               BRIGHT_SIG,
    input  logic [7:0]         CONTRAST,
    input  logic [7:0]         BRIGHT,
    output logic               Vsync_o,
    output logic               Hsync_o,
    output logic               De_o,
    output logic [CH*DW-1:0]   Data_o,
    output logic               Upd_o
);

    // Active level of Vsync and the arithmetic constants of the datapath.
    localparam logic                   c_VS_ACT = (VS_POL != 0);
    localparam logic                   c_IMMED  = (UPD_MODE != 0);
    localparam logic signed [DW:0]     c_MID_D  = (DW+1)'(2**(DW-1));
    localparam logic signed [DW+11:0]  c_MID_R  = (DW+12)'(2**(DW-1));
    localparam logic signed [DW+11:0]  c_RND    = (DW+12)'(64);
    localparam logic signed [DW+11:0]  c_MAX_R  = (DW+12)'(2**DW - 1);

    // Sync pipeline, Vsync edge detector, active controls, update pulse.
    logic        r_vs_q;
    logic [2:0]  r_vs_d;
    logic [2:0]  r_hs_d;
    logic [2:0]  r_de_d;
    logic [7:0]  r_c_act;
    logic [7:0]  r_b_act;
    logic        r_csig_act;
    logic        r_bsig_act;
    logic        r_upd;

    logic        w_vs_lead;
    logic        w_load;

    assign w_vs_lead = (r_vs_q != c_VS_ACT) && (Vsync == c_VS_ACT);
    assign w_load    = c_IMMED || w_vs_lead;

    // Shadow-load the controls and delay the syncs through three stages.
    always_ff @(posedge Pclk) begin
        if (Rst) begin
            r_vs_q     <= ~c_VS_ACT;
            r_vs_d     <= 3'b000;
            r_hs_d     <= 3'b000;
            r_de_d     <= 3'b000;
            r_c_act    <= 8'd128;
            r_b_act    <= 8'd0;
            r_csig_act <= 1'b0;
            r_bsig_act <= 1'b0;
            r_upd      <= 1'b0;
        end else begin
            r_vs_q <= Vsync;
            r_vs_d <= {r_vs_d[1:0], Vsync};
            r_hs_d <= {r_hs_d[1:0], Hsync};
            r_de_d <= {r_de_d[1:0], De};
            r_upd  <= (!c_IMMED) && w_vs_lead;
            if (w_load) begin
                r_c_act    <= CONTRAST;
                r_b_act    <= BRIGHT;
                r_csig_act <= CONTRAST_SIG;
                r_bsig_act <= BRIGHT_SIG;
            end
        end
    end

    assign Vsync_o = r_vs_d[2];
    assign Hsync_o = r_hs_d[2];
    assign De_o    = r_de_d[2];
    assign Upd_o   = r_upd;

    // Effective gain (read by stage 2) and offset (read by stage 3). Both use
    // the active registers as they stand, so a load reaches pixels in flight.
    logic [7:0]              w_gain;
    logic signed [DW+9:0]    w_gain_x;
    logic signed [DW-1:0]    w_b_ext;
    logic signed [DW-1:0]    w_off;
    logic signed [DW+11:0]   w_off_x;

    assign w_gain   = r_csig_act ? r_c_act : 8'd128;
    assign w_gain_x = (DW+10)'($signed({1'b0, w_gain}));
    assign w_b_ext  = DW'($signed(r_b_act));
    assign w_off    = r_bsig_act ? (w_b_ext <<< (DW-8)) : '0;
    assign w_off_x  = (DW+12)'(w_off);

    // Independent per-channel datapaths sharing gain and offset.
    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [DW-1:0]          w_in;
        logic signed [DW:0]     r_d;
        logic signed [DW+9:0]   w_d_x;
        logic signed [DW+9:0]   r_p;
        logic signed [DW+11:0]  w_p_x;
        logic signed [DW+11:0]  w_r;
        logic [DW-1:0]          r_out;

        assign w_in  = Data[c*DW +: DW];
        assign w_d_x = (DW+10)'(r_d);
        assign w_p_x = (DW+12)'(r_p);
        // Round half up, arithmetic shift floors negative products.
        assign w_r   = ((w_p_x + c_RND) >>> 7) + c_MID_R + w_off_x;

        // Stage 1: centre the sample around mid-scale.
        always_ff @(posedge Pclk) begin
            if (Rst) begin
                r_d <= '0;
            end else begin
                r_d <= $signed({1'b0, w_in}) - c_MID_D;
            end
        end

        // Stage 2: apply the gain.
        always_ff @(posedge Pclk) begin
            if (Rst) begin
                r_p <= '0;
            end else begin
                r_p <= w_d_x * w_gain_x;
            end
        end

        // Stage 3: rescale, re-centre, add offset, saturate; blank outside De.
        always_ff @(posedge Pclk) begin
            if (Rst) begin
                r_out <= '0;
            end else if (!r_de_d[1]) begin
                r_out <= '0;
            end else if (w_r[DW+11]) begin
                r_out <= '0;
            end else if (w_r > c_MAX_R) begin
                r_out <= '1;
            end else begin
                r_out <= w_r[DW-1:0];
            end
        end

        assign Data_o[c*DW +: DW] = r_out;
    end

endmodule
`default_nettype wire

// File: tb/tb_contrast_bright_px.sv
`default_nettype none
// ============================================================================
//  Module      : tb_contrast_bright_px
//  Description : Self-checking bench for contrast_bright_px. Two instances
//                (frame-synchronous and immediate control load) share one
//                stimulus stream and are checked every cycle against a
//                behavioural model, plus hand-computed pixel expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_contrast_bright_px;

    localparam int DW = 8;
    localparam int CH = 3;
    localparam int W  = CH*DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         vsync;
    logic         hsync;
    logic         de;
    logic [W-1:0] data;
    logic         csig;
    logic         bsig;
    logic [7:0]   contrast;
    logic [7:0]   bright;

    logic [1:0]   vs_o;
    logic [1:0]   hs_o;
    logic [1:0]   de_o;
    logic [1:0]   upd_o;
    logic [W-1:0] data_o [2];

    contrast_bright_px #(.DW(DW), .CH(CH), .VS_POL(1), .UPD_MODE(0)) u_dut0 (
        .Pclk(clk), .Rst(rst), .Vsync(vsync), .Hsync(hsync), .De(de), .Data(data),
        .CONTRAST_SIG(csig), .BRIGHT_SIG(bsig), .CONTRAST(contrast), .BRIGHT(bright),
        .Vsync_o(vs_o[0]), .Hsync_o(hs_o[0]), .De_o(de_o[0]), .Data_o(data_o[0]),
        .Upd_o(upd_o[0])
    );

    contrast_bright_px #(.DW(DW), .CH(CH), .VS_POL(1), .UPD_MODE(1)) u_dut1 (
        .Pclk(clk), .Rst(rst), .Vsync(vsync), .Hsync(hsync), .De(de), .Data(data),
        .CONTRAST_SIG(csig), .BRIGHT_SIG(bsig), .CONTRAST(contrast), .BRIGHT(bright),
        .Vsync_o(vs_o[1]), .Hsync_o(hs_o[1]), .De_o(de_o[1]), .Data_o(data_o[1]),
        .Upd_o(upd_o[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference pixel transform from the gain/offset rules.
    function automatic int px(input int v, input int g, input int o);
        int r;
        r = (((v - 128) * g + 64) >>> 7) + 128 + o;
        if (r < 0)   r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        bit           rst;
        bit           vs;
        bit           hs;
        bit           de;
        logic [W-1:0] data;
        int           g;
        int           o;
        bit           upd;
    } ent_t;

    ent_t         hist [2][3];
    bit           m_cs  [2];
    bit           m_bs  [2];
    logic [7:0]   m_c   [2];
    logic [7:0]   m_b   [2];
    bit           m_pvs [2];
    bit           exp_vs  [2];
    bit           exp_hs  [2];
    bit           exp_de  [2];
    bit           exp_upd [2];
    logic [W-1:0] exp_data [2];

    initial begin
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < 3; k++) begin
                hist[m][k].rst = 1'b1;
                hist[m][k].upd = 1'b0;
            end
    end

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            ent_t e;
            bit   lead;
            hist[m][2] = hist[m][1];
            hist[m][1] = hist[m][0];
            e.rst  = rst;
            e.vs   = vsync;
            e.hs   = hsync;
            e.de   = de;
            e.data = data;
            e.upd  = 1'b0;
            if (rst) begin
                m_c[m] = 8'd128; m_b[m] = 8'd0; m_cs[m] = 1'b0; m_bs[m] = 1'b0;
                m_pvs[m] = 1'b0;
            end else begin
                lead = !m_pvs[m] && vsync;
                if (m == 1 || lead) begin
                    m_c[m] = contrast; m_b[m] = bright; m_cs[m] = csig; m_bs[m] = bsig;
                end
                e.upd = (m == 0) && lead;
                m_pvs[m] = vsync;
            end
            e.g = m_cs[m] ? int'(m_c[m]) : 128;
            e.o = m_bs[m] ? int'($signed(m_b[m])) : 0;
            hist[m][0] = e;
            exp_upd[m] = hist[m][0].upd;
            if (hist[m][0].rst || hist[m][1].rst || hist[m][2].rst) begin
                exp_vs[m] = 1'b0; exp_hs[m] = 1'b0; exp_de[m] = 1'b0; exp_data[m] = '0;
            end else begin
                exp_vs[m] = hist[m][2].vs;
                exp_hs[m] = hist[m][2].hs;
                exp_de[m] = hist[m][2].de;
                exp_data[m] = '0;
                if (hist[m][2].de)
                    for (int ch = 0; ch < CH; ch++)
                        exp_data[m][ch*DW +: DW] =
                            DW'(px(int'(hist[m][2].data[ch*DW +: DW]), hist[m][2].g, hist[m][1].o));
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                check($sformatf("m%0d vsync_o", m), int'(vs_o[m]),  int'(exp_vs[m]));
                check($sformatf("m%0d hsync_o", m), int'(hs_o[m]),  int'(exp_hs[m]));
                check($sformatf("m%0d de_o", m),    int'(de_o[m]),  int'(exp_de[m]));
                check($sformatf("m%0d upd_o", m),   int'(upd_o[m]), int'(exp_upd[m]));
                check($sformatf("m%0d data_o", m),  int'(data_o[m]), int'(exp_data[m]));
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic load(input bit cs, input bit bs, input int c, input int b);
        logic [7:0] c8;
        logic [7:0] b8;
        c8 = c[7:0];
        b8 = b[7:0];
        @(negedge clk);
        csig = cs; bsig = bs; contrast = c8; bright = b8; vsync = 1'b1; de = 1'b0;
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
    endtask

    task automatic pix_chk(input int v, input int e0, input int e1);
        logic [7:0] v8;
        v8 = v[7:0];
        @(negedge clk);
        de = 1'b1; data = {CH{v8}};
        @(negedge clk);
        de = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check($sformatf("lit m0 in=%0d ch0", v), int'(data_o[0][7:0]),   e0);
        check($sformatf("lit m0 in=%0d ch2", v), int'(data_o[0][23:16]), e0);
        check($sformatf("lit m1 in=%0d ch1", v), int'(data_o[1][15:8]),  e1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; vsync = 1'b0; hsync = 1'b0; de = 1'b0; data = '0;
        csig = 1'b0; bsig = 1'b0; contrast = 8'd0; bright = 8'd0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset data_o", int'(data_o[0]), 0);
        check("reset upd_o",  int'(upd_o[0]), 0);
        rst = 1'b0;

        // Unity gain/zero offset: ramp on all channels.
        load(1'b1, 1'b1, 128, 0);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            de = 1'b1; hsync = i[3]; data = {CH{i[7:0]}};
        end
        @(negedge clk);
        de = 1'b0; hsync = 1'b0;
        pix_chk(37, 37, 37);

        // Max gain with clamping.
        load(1'b1, 1'b0, 255, 0);
        pix_chk(200, 255, 255);
        pix_chk(50, 0, 0);
        pix_chk(128, 128, 128);

        // Reduced gain, round half up and floor on negatives.
        load(1'b1, 1'b0, 64, 0);
        pix_chk(200, 164, 164);
        pix_chk(56, 92, 92);

        // Brightness offset only.
        load(1'b0, 1'b1, 128, 8'h14);
        pix_chk(250, 255, 255);
        pix_chk(100, 120, 120);
        load(1'b0, 1'b1, 128, 8'hEC);
        pix_chk(10, 0, 0);
        pix_chk(100, 80, 80);

        // Mid-frame control change: only the immediate instance follows it.
        load(1'b1, 1'b0, 128, 0);
        @(negedge clk);
        contrast = 8'd64;
        pix_chk(200, 200, 164);
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        check("upd pulse m0", int'(upd_o[0]), 1);
        check("upd pulse m1", int'(upd_o[1]), 0);
        @(negedge clk);
        check("upd single m0", int'(upd_o[0]), 0);
        vsync = 1'b0;
        pix_chk(200, 164, 164);

        // Reset in the middle of an active line.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            de = 1'b1; data = {CH{8'(60 + i)}};
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst mid de_o",   int'(de_o[0]),   0);
        check("rst mid data_o", int'(data_o[0]), 0);
        check("rst mid data_o m1", int'(data_o[1]), 0);
        rst = 1'b0; de = 1'b0;
        pix_chk(200, 200, 164);

        // Randomised frames with occasional control changes and resets.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int pos;
            int ln;
            pos = cyc % 400;
            ln  = pos % 50;
            @(negedge clk);
            vsync = (pos < 8);
            hsync = (ln < 4);
            de    = (pos >= 20) && (ln >= 8) && (ln < 46);
            data  = W'($urandom());
            rst   = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 39) == 0) begin
                csig = 1'($urandom()); bsig = 1'($urandom());
                contrast = 8'($urandom()); bright = 8'($urandom());
            end
        end
        @(negedge clk);
        rst = 1'b0; de = 1'b0; vsync = 1'b0; hsync = 1'b0;
        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
